// File: rtl/bus_sequencer_pkg.sv
// Shared types and constants for the 68000-style bus sequencer: FSM states,
// address-region codes and the single I/O port address.
package bus_sequencer_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_STEP,
        S_ACK,
        S_BERR,
        S_HOLD
    } state_t;

    localparam logic [3:0]        REGION_LOWER = 4'h0;
    localparam logic [3:0]        REGION_IO    = 4'h1;
    localparam logic [3:0]        REGION_UPPER = 4'hF;
    localparam logic [ADDR_W-1:0] IO_PORT_ADDR = 24'h100001;

endpackage

// File: rtl/bus_sequencer_if.sv
// Bus-side signal bundle of the sequencer; master is the CPU/bench side,
// slave is the sequencer itself.
interface bus_sequencer_if
    import bus_sequencer_pkg::*;
#(
    parameter int unsigned IO_W = 4
) ();
    logic              RUN_IN;
    logic              AS_IN;
    logic              WR_IN;
    logic              UDS_IN;
    logic              LDS_IN;
    logic              STEPEN_IN;
    logic              STEP_IN;
    logic [ADDR_W-1:0] ADDR_IN;
    logic [IO_W-1:0]   INPUT_SIGNAL_IN;
    logic              DTACK;
    logic              BERR;
    logic              PROMCS0;
    logic              PROMCS1;
    logic              SRAMCS0;
    logic              SRAMCS1;
    logic              OE;
    logic [IO_W-1:0]   OUTPUT_SIGNAL;
    logic              BOOTSTRAPPED;

    modport master (
        output RUN_IN, AS_IN, WR_IN, UDS_IN, LDS_IN, STEPEN_IN, STEP_IN,
               ADDR_IN, INPUT_SIGNAL_IN,
        input  DTACK, BERR, PROMCS0, PROMCS1, SRAMCS0, SRAMCS1, OE,
               OUTPUT_SIGNAL, BOOTSTRAPPED
    );

    modport slave (
        input  RUN_IN, AS_IN, WR_IN, UDS_IN, LDS_IN, STEPEN_IN, STEP_IN,
               ADDR_IN, INPUT_SIGNAL_IN,
        output DTACK, BERR, PROMCS0, PROMCS1, SRAMCS0, SRAMCS1, OE,
               OUTPUT_SIGNAL, BOOTSTRAPPED
    );
endinterface

// File: rtl/bus_wait_timer.sv
// 8-bit loadable down-counter with a zero flag; counts wait states for the
// sequencer and saturates at zero.
module bus_wait_timer
    import bus_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             dec,
    output logic             zero_c
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);
endmodule

// File: rtl/bus_sequencer.sv
// Address decode, chip selects and DTACK/BERR generation for a 68000 bus.
// Optional single-step mode is built when STEPPER_EN is defined.
module bus_sequencer
    import bus_sequencer_pkg::*;
#(
    parameter int unsigned ROM_WAIT    = 2,
    parameter int unsigned RAM_WAIT    = 0,
    parameter int unsigned IO_W        = 4,
    parameter int unsigned BERR_CYCLES = 16
) (
    input  logic              MCLK_IN,
    input  logic              RESET_IN,
    inout  wire  [DATA_W-1:0] DATA,
    bus_sequencer_if.slave    bus
);
    state_t           state;
    state_t           state_next;
    logic             timer_load;
    logic             timer_dec;
    logic [CNT_W-1:0] timer_value;
    logic             timer_zero;
    logic             step_go;
    logic             step_fire;

    // Address decode and chip selects (combinational)
    logic [3:0]       region;
    logic             lower, upper, io_hit, mapped;
    logic             prom_sel, sram_sel, access, dtreq;
    logic [CNT_W-1:0] wait_n;

    assign region   = bus.ADDR_IN[ADDR_W-1:ADDR_W-4];
    assign lower    = (region == REGION_LOWER);
    assign upper    = (region == REGION_UPPER);
    assign io_hit   = (region == REGION_IO) && (bus.ADDR_IN == IO_PORT_ADDR);
    assign mapped   = lower | upper | io_hit;
    assign prom_sel = upper | (lower & ~bus.BOOTSTRAPPED & ~bus.WR_IN);
    assign sram_sel = lower & ~prom_sel;
    assign access   = bus.RUN_IN & bus.AS_IN;
    assign dtreq    = access & (bus.UDS_IN | bus.LDS_IN);
    assign wait_n   = prom_sel ? CNT_W'(ROM_WAIT) : (sram_sel ? CNT_W'(RAM_WAIT) : '0);

    assign bus.PROMCS0 = access & bus.UDS_IN & prom_sel;
    assign bus.PROMCS1 = access & bus.LDS_IN & prom_sel;
    assign bus.SRAMCS0 = access & bus.UDS_IN & sram_sel;
    assign bus.SRAMCS1 = access & bus.LDS_IN & sram_sel;
    assign bus.OE      = access & (prom_sel | sram_sel) & ~bus.WR_IN;

    bus_wait_timer u_timer (
        .clk    (MCLK_IN),
        .rst    (RESET_IN),
        .load   (timer_load),
        .value  (timer_value),
        .dec    (timer_dec),
        .zero_c (timer_zero)
    );

`ifdef STEPPER_EN
    // One acknowledge per press: latch arms on the STEP->ACK edge, rearms on release
    logic step_latch;

    assign step_go   = bus.STEPEN_IN;
    assign step_fire = bus.STEP_IN & ~step_latch;

    always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            step_latch <= 1'b0;
        end else if ((state == S_STEP) && (state_next == S_ACK)) begin
            step_latch <= 1'b1;
        end else if (!bus.STEP_IN) begin
            step_latch <= 1'b0;
        end
    end
`else
    logic unused_step;

    assign step_go     = 1'b0;
    assign step_fire   = 1'b0;
    assign unused_step = bus.STEPEN_IN ^ bus.STEP_IN;
`endif

    always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counter holds N-1 so the acknowledge lands exactly N edges after the request
    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;
        timer_value = '0;
        case (state)
            S_IDLE: begin
                if (dtreq) begin
                    if (!mapped) begin
                        timer_load  = 1'b1;
                        timer_value = CNT_W'(BERR_CYCLES - 1);
                        state_next  = S_WAIT;
                    end else if (wait_n == '0) begin
                        state_next = step_go ? S_STEP : S_ACK;
                    end else begin
                        timer_load  = 1'b1;
                        timer_value = wait_n - CNT_W'(1);
                        state_next  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!dtreq) begin
                    state_next = S_IDLE;
                end else if (timer_zero) begin
                    state_next = !mapped ? S_BERR : (step_go ? S_STEP : S_ACK);
                end else begin
                    timer_dec = 1'b1;
                end
            end
`ifdef STEPPER_EN
            S_STEP: begin
                if (!dtreq) begin
                    state_next = S_IDLE;
                end else if (step_fire) begin
                    state_next = S_ACK;
                end
            end
`endif
            S_ACK, S_BERR: begin
                if (!dtreq) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Registered acknowledges plus write side effects on the ACK-entry edge
    logic ack_entry;

    assign ack_entry = (state_next == S_ACK) && (state != S_ACK);

    always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            bus.DTACK         <= 1'b0;
            bus.BERR          <= 1'b0;
            bus.OUTPUT_SIGNAL <= '0;
            bus.BOOTSTRAPPED  <= 1'b0;
        end else begin
            bus.DTACK <= (state_next == S_ACK);
            bus.BERR  <= (state_next == S_BERR);
            if (ack_entry && bus.WR_IN && lower) begin
                bus.BOOTSTRAPPED <= 1'b1;
            end
            if (ack_entry && bus.WR_IN && io_hit) begin
                bus.OUTPUT_SIGNAL <= DATA[IO_W+3:4];
            end
        end
    end

    logic              io_rd;
    logic [3:0]        in_low;
    logic [DATA_W-1:0] rd_word;
    logic              unused_in;

    assign io_rd     = (state == S_ACK) && io_hit && !bus.WR_IN;
    assign in_low    = 4'(bus.INPUT_SIGNAL_IN);
    assign rd_word   = DATA_W'({bus.OUTPUT_SIGNAL, in_low});
    assign DATA      = io_rd ? rd_word : {DATA_W{1'bz}};
    assign unused_in = ^{DATA, bus.INPUT_SIGNAL_IN};
endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: directed scenarios plus randomized
// bus cycles scored against a behavioural model of the decode/timing rules.
module tb_bus_sequencer;
    localparam int unsigned ROM_WAIT    = 2;
    localparam int unsigned RAM_WAIT    = 0;
    localparam int unsigned IO_W        = 4;
    localparam int unsigned BERR_CYCLES = 16;

    logic        clk;
    logic        rst;
    logic        tb_drive;
    logic [15:0] tb_data;
    wire  [15:0] data_bus;

    int errors = 0;
    int checks = 0;

    bit             m_boot = 1'b0;
    logic [IO_W-1:0] m_out = '0;

    bus_sequencer_if #(.IO_W(IO_W)) bus ();

    assign data_bus = tb_drive ? tb_data : 16'hzzzz;

    bus_sequencer #(
        .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT), .IO_W(IO_W), .BERR_CYCLES(BERR_CYCLES)
    ) dut (
        .MCLK_IN (clk),
        .RESET_IN(rst),
        .DATA    (data_bus),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  promcs;
        logic [1:0]  sramcs;
        logic        oe;
        logic        early;
        int          lat;
        logic        dtack;
        logic        berr;
        logic        both;
        logic [15:0] rdata;
        logic        held;
        logic        cleared;
    } obs_t;

    typedef struct {
        bit          mapped;
        bit          io;
        logic [1:0]  promcs;
        logic [1:0]  sramcs;
        logic        oe;
        int          lat;
    } exp_t;

    // Behavioural expectation of one access, from the decode and wait rules
    function automatic exp_t model(input logic [23:0] a, input bit wr, input bit uds, input bit lds);
        exp_t e;
        logic [3:0] top;
        bit lo, up, prom, sram;
        top  = a[23:20];
        lo   = (top == 4'h0);
        up   = (top == 4'hF);
        e.io = (a == 24'h100001);
        prom = up || (lo && !m_boot && !wr);
        sram = lo && !prom;
        e.mapped = lo || up || e.io;
        e.promcs = prom ? {lds, uds} : 2'b00;
        e.sramcs = sram ? {lds, uds} : 2'b00;
        e.oe     = (prom || sram) && !wr;
        if (!e.mapped)  e.lat = int'(BERR_CYCLES);
        else if (prom)  e.lat = int'(ROM_WAIT);
        else if (sram)  e.lat = int'(RAM_WAIT);
        else            e.lat = 0;
        return e;
    endfunction

    // Drives one full bus cycle and records what the DUT did; no checking here
    task automatic bus_cycle(input logic [23:0] a, input bit wr, input bit uds, input bit lds,
                             input logic [15:0] wd, input logic [IO_W-1:0] inp, output obs_t o);
        @(posedge clk); #1;
        bus.ADDR_IN = a; bus.WR_IN = wr; bus.UDS_IN = uds; bus.LDS_IN = lds;
        bus.INPUT_SIGNAL_IN = inp; tb_data = wd; tb_drive = wr; bus.AS_IN = 1'b1;
        @(negedge clk);
        o.promcs = {bus.PROMCS1, bus.PROMCS0};
        o.sramcs = {bus.SRAMCS1, bus.SRAMCS0};
        o.oe     = bus.OE;
        o.early  = bus.DTACK | bus.BERR;
        o.lat    = -1;
        o.both   = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.DTACK && bus.BERR) o.both = 1'b1;
            if (bus.DTACK || bus.BERR) begin
                o.lat = c;
                break;
            end
        end
        o.dtack = bus.DTACK;
        o.berr  = bus.BERR;
        o.rdata = data_bus;
        @(posedge clk); #1;
        bus.AS_IN = 1'b0; bus.UDS_IN = 1'b0; bus.LDS_IN = 1'b0; bus.WR_IN = 1'b0; tb_drive = 1'b0;
        @(negedge clk);
        o.held = bus.DTACK | bus.BERR;
        @(posedge clk); @(negedge clk);
        o.cleared = bus.DTACK | bus.BERR;
    endtask

    task automatic test_reset;
        rst = 1'b1; tb_drive = 1'b0; tb_data = '0;
        bus.RUN_IN = 1'b1; bus.AS_IN = 1'b0; bus.WR_IN = 1'b0; bus.UDS_IN = 1'b0; bus.LDS_IN = 1'b0;
        bus.STEPEN_IN = 1'b0; bus.STEP_IN = 1'b0; bus.ADDR_IN = '0; bus.INPUT_SIGNAL_IN = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.DTACK !== 1'b0) begin errors++; $display("FAIL reset_dtack: got %b expected 0", bus.DTACK); end
        checks++; if (bus.BERR !== 1'b0) begin errors++; $display("FAIL reset_berr: got %b expected 0", bus.BERR); end
        checks++; if (bus.OUTPUT_SIGNAL !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", bus.OUTPUT_SIGNAL); end
        checks++; if (bus.BOOTSTRAPPED !== 1'b0) begin errors++; $display("FAIL reset_boot: got %b expected 0", bus.BOOTSTRAPPED); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_boot = 1'b0; m_out = '0;
    endtask

    task automatic test_prom_read;
        obs_t o;
        bus_cycle(24'hF00000, 1'b0, 1'b1, 1'b1, 16'h0, '0, o);
        checks++; if (o.promcs !== 2'b11 || o.sramcs !== 2'b00 || o.oe !== 1'b1) begin
            errors++; $display("FAIL prom_sel: got prom=%b sram=%b oe=%b expected 11 00 1", o.promcs, o.sramcs, o.oe); end
        checks++; if (o.early !== 1'b0) begin errors++; $display("FAIL prom_early: got %b expected 0", o.early); end
        checks++; if (o.lat !== int'(ROM_WAIT) || o.dtack !== 1'b1 || o.berr !== 1'b0) begin
            errors++; $display("FAIL prom_lat: got lat=%0d dtack=%b berr=%b expected %0d 1 0", o.lat, o.dtack, o.berr, ROM_WAIT); end
        checks++; if (o.held !== 1'b1 || o.cleared !== 1'b0) begin
            errors++; $display("FAIL prom_release: got held=%b cleared=%b expected 1 0", o.held, o.cleared); end
    endtask

    task automatic test_boot_write;
        obs_t o;
        bus_cycle(24'h000010, 1'b1, 1'b1, 1'b1, 16'h1234, '0, o);
        checks++; if (o.sramcs !== 2'b11 || o.promcs !== 2'b00 || o.oe !== 1'b0) begin
            errors++; $display("FAIL boot_wr_sel: got prom=%b sram=%b oe=%b expected 00 11 0", o.promcs, o.sramcs, o.oe); end
        checks++; if (o.lat !== int'(RAM_WAIT) || o.dtack !== 1'b1) begin
            errors++; $display("FAIL boot_wr_lat: got lat=%0d dtack=%b expected %0d 1", o.lat, o.dtack, RAM_WAIT); end
        checks++; if (bus.BOOTSTRAPPED !== 1'b1) begin errors++; $display("FAIL boot_flag: got %b expected 1", bus.BOOTSTRAPPED); end
        m_boot = 1'b1;
        bus_cycle(24'h000020, 1'b0, 1'b1, 1'b0, 16'h0, '0, o);
        checks++; if (o.sramcs !== 2'b01 || o.promcs !== 2'b00 || o.oe !== 1'b1) begin
            errors++; $display("FAIL boot_rd_sel: got prom=%b sram=%b oe=%b expected 00 01 1", o.promcs, o.sramcs, o.oe); end
    endtask

    task automatic test_io;
        obs_t o;
        bus_cycle(24'h100001, 1'b1, 1'b0, 1'b1, 16'h00A5, '0, o);
        checks++; if (o.lat !== 0 || o.dtack !== 1'b1 || o.promcs !== 2'b00 || o.sramcs !== 2'b00) begin
            errors++; $display("FAIL io_wr: got lat=%0d dtack=%b cs=%b%b expected 0 1 0000", o.lat, o.dtack, o.promcs, o.sramcs); end
        checks++; if (bus.OUTPUT_SIGNAL !== 4'hA) begin errors++; $display("FAIL io_out: got %h expected a", bus.OUTPUT_SIGNAL); end
        m_out = 4'hA;
        bus_cycle(24'h100001, 1'b0, 1'b0, 1'b1, 16'h0, 4'h3, o);
        checks++; if (o.rdata !== 16'h00A3 || o.dtack !== 1'b1) begin
            errors++; $display("FAIL io_rd: got data=%h dtack=%b expected 00a3 1", o.rdata, o.dtack); end
        bus_cycle(24'h100003, 1'b0, 1'b0, 1'b1, 16'h0, 4'h3, o);
        checks++; if (o.berr !== 1'b1 || o.dtack !== 1'b0 || o.lat !== int'(BERR_CYCLES)) begin
            errors++; $display("FAIL io_unmapped: got berr=%b dtack=%b lat=%0d expected 1 0 %0d", o.berr, o.dtack, o.lat, BERR_CYCLES); end
    endtask

    task automatic test_berr;
        obs_t o;
        bus_cycle(24'h500000, 1'b0, 1'b1, 1'b1, 16'h0, '0, o);
        checks++; if (o.promcs !== 2'b00 || o.sramcs !== 2'b00 || o.oe !== 1'b0) begin
            errors++; $display("FAIL berr_sel: got prom=%b sram=%b oe=%b expected 00 00 0", o.promcs, o.sramcs, o.oe); end
        checks++; if (o.lat !== int'(BERR_CYCLES) || o.berr !== 1'b1 || o.dtack !== 1'b0 || o.both !== 1'b0) begin
            errors++; $display("FAIL berr_lat: got lat=%0d berr=%b dtack=%b both=%b expected %0d 1 0 0", o.lat, o.berr, o.dtack, o.both, BERR_CYCLES); end
        checks++; if (o.held !== 1'b1 || o.cleared !== 1'b0) begin
            errors++; $display("FAIL berr_release: got held=%b cleared=%b expected 1 0", o.held, o.cleared); end
    endtask

    task automatic test_abort;
        obs_t o;
        logic seen;
        seen = 1'b0;
        @(posedge clk); #1;
        bus.ADDR_IN = 24'h500000; bus.WR_IN = 1'b0; bus.UDS_IN = 1'b1; bus.LDS_IN = 1'b1; bus.AS_IN = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus.AS_IN = 1'b0; bus.UDS_IN = 1'b0; bus.LDS_IN = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.DTACK || bus.BERR) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_quiet: got ack=%b expected 0", seen); end
        bus_cycle(24'hF00002, 1'b0, 1'b1, 1'b1, 16'h0, '0, o);
        checks++; if (o.lat !== int'(ROM_WAIT) || o.dtack !== 1'b1) begin
            errors++; $display("FAIL abort_recover: got lat=%0d dtack=%b expected %0d 1", o.lat, o.dtack, ROM_WAIT); end
    endtask

`ifdef STEPPER_EN
    task automatic test_stepper;
        bus.STEPEN_IN = 1'b1; bus.STEP_IN = 1'b0;
        @(posedge clk); #1;
        bus.ADDR_IN = 24'hF00000; bus.WR_IN = 1'b0; bus.UDS_IN = 1'b1; bus.LDS_IN = 1'b1; bus.AS_IN = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.DTACK !== 1'b0) begin errors++; $display("FAIL step_hold: got %b expected 0", bus.DTACK); end
        @(posedge clk); #1 bus.STEP_IN = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (bus.DTACK !== 1'b1) begin errors++; $display("FAIL step_press: got %b expected 1", bus.DTACK); end
        @(posedge clk); #1 bus.AS_IN = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.AS_IN = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.DTACK !== 1'b0) begin errors++; $display("FAIL step_held_once: got %b expected 0", bus.DTACK); end
        @(posedge clk); #1 bus.STEP_IN = 1'b0;
        @(posedge clk); #1 bus.STEP_IN = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (bus.DTACK !== 1'b1) begin errors++; $display("FAIL step_repress: got %b expected 1", bus.DTACK); end
        @(posedge clk); #1;
        bus.AS_IN = 1'b0; bus.UDS_IN = 1'b0; bus.LDS_IN = 1'b0; bus.STEP_IN = 1'b0; bus.STEPEN_IN = 1'b0;
        repeat (2) @(posedge clk);
    endtask
`else
    task automatic test_stepper;
        obs_t o;
        bus.STEPEN_IN = 1'b1; bus.STEP_IN = 1'b0;
        bus_cycle(24'hF00004, 1'b0, 1'b1, 1'b1, 16'h0, '0, o);
        checks++; if (o.lat !== int'(ROM_WAIT) || o.dtack !== 1'b1) begin
            errors++; $display("FAIL step_ignored: got lat=%0d dtack=%b expected %0d 1", o.lat, o.dtack, ROM_WAIT); end
        bus.STEPEN_IN = 1'b0;
    endtask
`endif

    task automatic test_reset_mid;
        obs_t o;
        logic [23:0] a;
        int c;
        bus_cycle(24'h100001, 1'b1, 1'b0, 1'b1, 16'h0050, '0, o);
        m_out = 4'h5;
        @(posedge clk); #1;
        bus.ADDR_IN = 24'h500000; bus.WR_IN = 1'b0; bus.UDS_IN = 1'b1; bus.LDS_IN = 1'b1; bus.AS_IN = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.DTACK !== 1'b0 || bus.BERR !== 1'b0) begin
            errors++; $display("FAIL rst_wait_ack: got dtack=%b berr=%b expected 0 0", bus.DTACK, bus.BERR); end
        checks++; if (bus.BOOTSTRAPPED !== 1'b0 || bus.OUTPUT_SIGNAL !== '0) begin
            errors++; $display("FAIL rst_wait_state: got boot=%b out=%h expected 0 0", bus.BOOTSTRAPPED, bus.OUTPUT_SIGNAL); end
        bus.AS_IN = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        m_boot = 1'b0; m_out = '0;
        // Reset while acknowledging must drop DTACK without waiting for an edge
        a = 24'hF00006;
        @(posedge clk); #1;
        bus.ADDR_IN = a; bus.AS_IN = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.DTACK && c < 20);
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.DTACK !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0 (waited %0d)", bus.DTACK, c); end
        bus.AS_IN = 1'b0; bus.UDS_IN = 1'b0; bus.LDS_IN = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_random;
        obs_t o;
        exp_t e;
        logic [23:0] a;
        logic [1:0]  s;
        logic [15:0] wd;
        logic [IO_W-1:0] inp;
        bit wr;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0:       a = {4'h0, 20'($urandom)};
                1:       a = 24'h100001;
                2:       a = {4'h1, 20'($urandom)};
                3:       a = {4'hF, 20'($urandom)};
                default: a = {4'($urandom_range(2, 14)), 20'($urandom)};
            endcase
            s   = 2'($urandom_range(1, 3));
            wr  = 1'($urandom);
            wd  = 16'($urandom);
            inp = IO_W'($urandom);
            e = model(a, wr, s[1], s[0]);
            bus_cycle(a, wr, s[1], s[0], wd, inp, o);
            checks++; if ({o.promcs, o.sramcs, o.oe} !== {e.promcs, e.sramcs, e.oe}) begin
                errors++; $display("FAIL rnd_sel[%0d] a=%h wr=%b: got %b_%b_%b expected %b_%b_%b",
                                   n, a, wr, o.promcs, o.sramcs, o.oe, e.promcs, e.sramcs, e.oe); end
            checks++; if (o.lat !== e.lat || o.early !== 1'b0) begin
                errors++; $display("FAIL rnd_lat[%0d] a=%h: got %0d early=%b expected %0d", n, a, o.lat, o.early, e.lat); end
            checks++; if ({o.dtack, o.berr, o.both} !== {e.mapped, !e.mapped, 1'b0}) begin
                errors++; $display("FAIL rnd_kind[%0d] a=%h: got dtack=%b berr=%b both=%b expected %b %b 0",
                                   n, a, o.dtack, o.berr, o.both, e.mapped, !e.mapped); end
            checks++; if (o.held !== 1'b1 || o.cleared !== 1'b0) begin
                errors++; $display("FAIL rnd_release[%0d]: got held=%b cleared=%b expected 1 0", n, o.held, o.cleared); end
            if (e.io && !wr) begin
                checks++; if (o.rdata !== {8'h00, m_out, inp[3:0]}) begin
                    errors++; $display("FAIL rnd_iord[%0d]: got %h expected %h", n, o.rdata, {8'h00, m_out, inp[3:0]}); end
            end
            if (wr && a[23:20] == 4'h0) m_boot = 1'b1;
            if (wr && e.io) m_out = wd[IO_W+3:4];
            checks++; if (bus.BOOTSTRAPPED !== m_boot || bus.OUTPUT_SIGNAL !== m_out) begin
                errors++; $display("FAIL rnd_state[%0d]: got boot=%b out=%h expected %b %h",
                                   n, bus.BOOTSTRAPPED, bus.OUTPUT_SIGNAL, m_boot, m_out); end
        end
    endtask

    initial begin
        test_reset();
        test_prom_read();
        test_boot_write();
        test_io();
        test_berr();
        test_abort();
        test_stepper();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
